meas_sequencer: RTL and testbench

- Parametrised successor to the key-triggered Tx/Re controller: sequences one measurement burst per trigger.
- Each shot runs: FIFO reset pulse → DAC transmit window (`enTx`) → guard gap → ADC receive window (`enRe`) → inter-shot gap.
- Adds what the old controller lacks: programmable shot count, continuous re-arm, abort, per-window timeout, and a software start.
- Sits between the DAC transmit block, the ADC/Ethernet capture block and the board key/LED, in the `clk_100` domain.

---
 rtl/meas_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_meas_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_sequencer.sv
// meas_sequencer
// Sequences one measurement burst per trigger. Every shot runs a capture
// FIFO reset pulse, a DAC transmit window, a guard gap, an ADC receive
// window and an optional inter-shot gap. A burst is started by a debounced
// key press or a software start, and can be repeated automatically
// (cont_mode), aborted, or ended early by a per-window timeout.
//
// Ports (all in the clk_100 domain except rst and key_in):
//   clk_100      block clock
//   rst          asynchronous active-high reset
//   key_in       raw active-low button (asynchronous)
//   start        software trigger
//   abort        return to IDLE on the next cycle
//   cont_mode    re-arm after each burst (sampled in DONE)
//   n_shots      shots per burst, 0 behaves as 1 (latched at trigger)
//   gap_cyc      idle cycles between shots (latched at trigger)
//   overTx       transmit block finished (only honoured in TX)
//   overRe       capture block finished (only honoured in RX)
//   enTx / enRe  transmit / receive enables
//   fifo_rst     capture FIFO reset
//   busy         high outside IDLE
//   done         one-cycle pulse at the end of a completed burst
//   timeout_err  sticky timeout flag, cleared by the next trigger
//   shot_cnt     completed shots in the current burst
//   temp_led     toggles once per completed burst
module meas_sequencer #(
    parameter int SHOT_W       = 8,
    parameter int GAP_W        = 16,
    parameter int RST_CYC      = 8,
    parameter int GUARD_CYC    = 16,
    parameter int TIMEOUT_CYC  = 1_000_000,
    parameter int DEBOUNCE_CYC = 2_000_000
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              key_in,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_mode,
    input  logic [SHOT_W-1:0] n_shots,
    input  logic [GAP_W-1:0]  gap_cyc,
    input  logic              overTx,
    input  logic              overRe,
    output logic              enTx,
    output logic              enRe,
    output logic              fifo_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [SHOT_W-1:0] shot_cnt,
    output logic              temp_led
);

    // One phase counter serves FRST, GUARD, GAP and the TX/RX timeout, so it
    // must be wide enough for the largest of those limits.
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int RG_W  = $clog2(((RST_CYC > GUARD_CYC) ? RST_CYC : GUARD_CYC) + 1);
    localparam int CW0   = (TO_W > GAP_W) ? TO_W : GAP_W;
    localparam int CNT_W = (CW0 > RG_W) ? CW0 : RG_W;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRST,
        S_TX,
        S_GUARD,
        S_RX,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   gap_last;
    logic [SHOT_W-1:0]  shots_lat, shots_lat_d;
    logic [GAP_W-1:0]   gap_lat, gap_lat_d;
    logic [SHOT_W-1:0]  shot_d;
    logic               err_d;

    logic               key_s1, key_s2, key_db, key_db_q;
    logic [DB_W-1:0]    db_cnt;
    logic               key_fall;
    logic               trigger;

    // Key path: two-flop synchroniser, then the debounced level follows the
    // synchronised level only once it has differed for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            key_db_q <= key_db;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_fall = key_db_q & ~key_db;
    assign trigger  = start | key_fall;
    assign gap_last = CNT_W'(gap_lat) - CNT_W'(1);

    // Next-state logic. Abort overrides everything, including a coincident
    // over* or timeout. Each state change resets the phase counter.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + 1'b1;
        shots_lat_d = shots_lat;
        gap_lat_d   = gap_lat;
        shot_d      = shot_cnt;
        err_d       = timeout_err;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_d = '0;
                    if (trigger) begin
                        shots_lat_d = (n_shots == '0) ? SHOT_W'(1) : n_shots;
                        gap_lat_d   = gap_cyc;
                        shot_d      = '0;
                        err_d       = 1'b0;
                        state_d     = S_FRST;
                    end
                end
                S_FRST: begin
                    if (cnt == RST_LAST) begin
                        state_d = S_TX;
                        cnt_d   = '0;
                    end
                end
                S_TX: begin
                    if (overTx) begin
                        state_d = S_GUARD;
                        cnt_d   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                S_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state_d = S_RX;
                        cnt_d   = '0;
                    end
                end
                S_RX: begin
                    if (overRe) begin
                        shot_d = shot_cnt + 1'b1;
                        cnt_d  = '0;
                        if (shot_d == shots_lat) begin
                            state_d = S_DONE;
                        end else if (gap_lat == '0) begin
                            state_d = S_FRST;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                S_GAP: begin
                    if (cnt == gap_last) begin
                        state_d = S_FRST;
                        cnt_d   = '0;
                    end
                end
                S_DONE: begin
                    cnt_d = '0;
                    if (cont_mode) begin
                        shot_d  = '0;
                        state_d = S_FRST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // in the same cycle as the state and come straight out of reset flops.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shots_lat   <= '0;
            gap_lat     <= '0;
            shot_cnt    <= '0;
            timeout_err <= 1'b0;
            enTx        <= 1'b0;
            enRe        <= 1'b0;
            fifo_rst    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            temp_led    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            shots_lat   <= shots_lat_d;
            gap_lat     <= gap_lat_d;
            shot_cnt    <= shot_d;
            timeout_err <= err_d;
            enTx        <= (state_d == S_TX);
            enRe        <= (state_d == S_RX);
            fifo_rst    <= (state_d == S_FRST);
            busy        <= (state_d != S_IDLE);
            done        <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                temp_led <= ~temp_led;
            end
        end
    end

endmodule

// File: tb/tb_meas_sequencer.sv
// Testbench for meas_sequencer. The expected behaviour is built as a list of
// per-cycle steps from a phase-level description of each burst (how many
// cycles of FRST, TX, GUARD, RX, GAP, DONE, IDLE), then replayed against the
// DUT, driving inputs and comparing outputs every cycle.
module tb_meas_sequencer;

    localparam int SHOT_W       = 4;
    localparam int GAP_W        = 4;
    localparam int RST_CYC      = 3;
    localparam int GUARD_CYC    = 4;
    localparam int TIMEOUT_CYC  = 100;
    localparam int DEBOUNCE_CYC = 20;
    localparam int OW           = 7 + SHOT_W;

    logic              clk_100 = 1'b0;
    logic              rst;
    logic              key_in, start, abort, cont_mode, overTx, overRe;
    logic [SHOT_W-1:0] n_shots;
    logic [GAP_W-1:0]  gap_cyc;
    logic              enTx, enRe, fifo_rst, busy, done, timeout_err, temp_led;
    logic [SHOT_W-1:0] shot_cnt;

    int tests  = 0;
    int failed = 0;

    meas_sequencer #(
        .SHOT_W(SHOT_W), .GAP_W(GAP_W), .RST_CYC(RST_CYC), .GUARD_CYC(GUARD_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk_100(clk_100), .rst(rst), .key_in(key_in), .start(start), .abort(abort),
        .cont_mode(cont_mode), .n_shots(n_shots), .gap_cyc(gap_cyc),
        .overTx(overTx), .overRe(overRe), .enTx(enTx), .enRe(enRe),
        .fifo_rst(fifo_rst), .busy(busy), .done(done), .timeout_err(timeout_err),
        .shot_cnt(shot_cnt), .temp_led(temp_led)
    );

    always #5 clk_100 = ~clk_100;

    // Phase the sequencer is expected to be in during a given cycle.
    typedef enum {K_IDLE, K_FRST, K_TX, K_GUARD, K_RX, K_GAP, K_DONE} kind_t;

    typedef struct {
        kind_t             kind;
        logic              start, abort, cont_mode, over_tx, over_re, key_in;
        logic [SHOT_W-1:0] n_shots;
        logic [GAP_W-1:0]  gap_cyc;
        logic [SHOT_W-1:0] exp_shot;
        logic              exp_led, exp_err;
        int                sc;
    } step_t;

    step_t             plan[$];
    logic [SHOT_W-1:0] m_shot = '0;
    logic              m_led  = 1'b0;
    logic              m_err  = 1'b0;
    logic              m_key  = 1'b1;
    int                cur_sc = 0;

    // Append n cycles of one phase. Inputs that the phase must ignore are
    // randomised; inputs that would matter are held inactive.
    task automatic push(input kind_t k, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.kind      = k;
            s.start     = (k == K_IDLE) ? 1'b0 : 1'($urandom_range(0, 1));
            s.abort     = 1'b0;
            s.cont_mode = 1'($urandom_range(0, 1));
            s.over_tx   = (k == K_TX) ? 1'b0 : 1'($urandom_range(0, 1));
            s.over_re   = (k == K_RX) ? 1'b0 : 1'($urandom_range(0, 1));
            s.key_in    = m_key;
            s.n_shots   = SHOT_W'($urandom);
            s.gap_cyc   = GAP_W'($urandom);
            s.exp_shot  = m_shot;
            s.exp_led   = m_led;
            s.exp_err   = m_err;
            s.sc        = cur_sc;
            plan.push_back(s);
        end
    endtask

    function automatic int last();
        return plan.size() - 1;
    endfunction

    // Marks the most recent idle cycle as the trigger cycle.
    task automatic armLast(input int n, input int gap);
        plan[last()].n_shots = SHOT_W'(n);
        plan[last()].gap_cyc = GAP_W'(gap);
        m_shot = '0;
        m_err  = 1'b0;
    endtask

    task automatic startTrigger(input int n, input int gap);
        push(K_IDLE, 1);
        plan[last()].start = 1'b1;
        armLast(n, gap);
    endtask

    // One shot: FRST, TX of dtx cycles, GUARD, RX of drx cycles, then DONE or GAP.
    task automatic addShot(input bit is_last, input int gap, input bit cont,
                           input bit abort_end, input int dtx, input int drx);
        push(K_FRST, RST_CYC);
        push(K_TX, dtx);
        plan[last()].over_tx = 1'b1;
        push(K_GUARD, GUARD_CYC);
        push(K_RX, drx);
        plan[last()].over_re = 1'b1;
        if (abort_end) begin
            plan[last()].abort = 1'b1;
        end else begin
            m_shot = m_shot + 1'b1;
            if (is_last) begin
                m_led = ~m_led;
                push(K_DONE, 1);
                plan[last()].cont_mode = cont;
                if (cont) m_shot = '0;
            end else if (gap > 0) begin
                push(K_GAP, gap);
            end
        end
    endtask

    task automatic addBurst(input int n, input int gap, input bit cont);
        int eff;
        eff = (n == 0) ? 1 : n;
        for (int s = 0; s < eff; s++)
            addShot(s == eff - 1, gap, cont, 1'b0, $urandom_range(1, 8), $urandom_range(1, 8));
    endtask

    task automatic applyStimulus(input step_t s);
        start     = s.start;
        abort     = s.abort;
        cont_mode = s.cont_mode;
        overTx    = s.over_tx;
        overRe    = s.over_re;
        key_in    = s.key_in;
        n_shots   = s.n_shots;
        gap_cyc   = s.gap_cyc;
    endtask

    task automatic checkOutput(input step_t s, input int idx);
        logic [OW-1:0] obs, expv;
        obs  = {busy, fifo_rst, enTx, enRe, done, timeout_err, temp_led, shot_cnt};
        expv = {s.kind != K_IDLE, s.kind == K_FRST, s.kind == K_TX, s.kind == K_RX,
                s.kind == K_DONE, s.exp_err, s.exp_led, s.exp_shot};
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("[TB] FAIL sc%0d cyc%0d outputs{busy,frst,tx,re,done,err,led,shot}: observed %b required %b",
                   s.sc, idx, obs, expv);
        end
    endtask

    task automatic runPlan();
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk_100);
            checkOutput(plan[i], i);
            applyStimulus(plan[i]);
        end
        plan.delete();
    endtask

    initial begin
        logic [OW-1:0] obs;
        rst = 1'b1; key_in = 1'b1; start = 1'b0; abort = 1'b0; cont_mode = 1'b0;
        overTx = 1'b0; overRe = 1'b0; n_shots = '0; gap_cyc = '0;
        repeat (3) @(negedge clk_100);
        rst = 1'b0;

        // 1: reset state, then three shots with fixed windows and a gap of 5
        cur_sc = 1;
        push(K_IDLE, 3);
        startTrigger(3, 5);
        for (int s = 0; s < 3; s++) addShot(s == 2, 5, 1'b0, 1'b0, 11, 21);
        push(K_IDLE, 4);

        // 2: zero shots behaves as one, zero gap
        cur_sc = 2;
        startTrigger(0, 0);
        addBurst(0, 0, 1'b0);
        push(K_IDLE, 3);

        // 3: continuous mode for two bursts, cleared during the third
        cur_sc = 3;
        startTrigger(2, 0);
        addBurst(2, 0, 1'b1);
        addBurst(2, 0, 1'b1);
        addBurst(2, 0, 1'b0);
        push(K_IDLE, 3);

        // 4: TX timeout, recovery by start, then RX timeout
        cur_sc = 4;
        startTrigger(2, 1);
        push(K_FRST, RST_CYC);
        push(K_TX, TIMEOUT_CYC + 1);
        m_err = 1'b1;
        push(K_IDLE, 3);
        startTrigger(1, 3);
        addBurst(1, 3, 1'b0);
        push(K_IDLE, 2);
        startTrigger(1, 0);
        push(K_FRST, RST_CYC);
        push(K_TX, 2);
        plan[last()].over_tx = 1'b1;
        push(K_GUARD, GUARD_CYC);
        push(K_RX, TIMEOUT_CYC + 1);
        m_err = 1'b1;
        push(K_IDLE, 3);

        // 5: abort together with the last overRe, then abort during FRST
        cur_sc = 5;
        startTrigger(2, 2);
        addShot(1'b0, 2, 1'b0, 1'b0, $urandom_range(1, 8), $urandom_range(1, 8));
        addShot(1'b1, 2, 1'b0, 1'b1, $urandom_range(1, 8), $urandom_range(1, 8));
        push(K_IDLE, 3);
        startTrigger(3, 1);
        push(K_FRST, 2);
        plan[last()].abort = 1'b1;
        push(K_IDLE, 3);

        // 6: bouncing key gives one trigger; release gives none
        cur_sc = 6;
        push(K_IDLE, 2);
        for (int t = 0; t < 4; t++) begin
            m_key = ~m_key;
            push(K_IDLE, 3);
        end
        m_key = 1'b0;
        push(K_IDLE, DEBOUNCE_CYC + 3);
        armLast(2, 1);
        addBurst(2, 1, 1'b0);
        push(K_IDLE, 3);
        m_key = 1'b1;
        push(K_IDLE, DEBOUNCE_CYC + 6);

        runPlan();

        // 7: asynchronous reset in the middle of TX
        cur_sc = 7;
        startTrigger(1, 0);
        push(K_FRST, RST_CYC);
        push(K_TX, 4);
        runPlan();
        #2;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #1;
        obs = {busy, fifo_rst, enTx, enRe, done, timeout_err, temp_led, shot_cnt};
        tests++;
        assert (obs === '0) else begin
            failed++;
            $error("[TB] FAIL async_reset: observed %b required %b", obs, {OW{1'b0}});
        end
        @(negedge clk_100);
        rst = 1'b0;
        m_led = 1'b0; m_shot = '0; m_err = 1'b0;
        push(K_IDLE, 2);
        startTrigger(1, 0);
        addBurst(1, 0, 1'b0);
        push(K_IDLE, 2);
        runPlan();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
